jtframe_cen_ratio_meter: RTL and testbench

Measures an incoming clock-enable stream against `clk` over a programmable window and reports the recovered numerator: the pulse count per `m` clock cycles. It also reports the minimum and maximum spacing between pulses. It is the checking end of the fractional cen generators. It sits beside a cen generator in debug and self-test logic, and confirms that a configured n/m ratio is actually delivered with at most one cycle of jitter.

---
 rtl/jtframe_cen_ratio_meter_pkg.sv | 19 +
 rtl/jtframe_cen_ratio_meter_gap_tracker.sv | 74 +++++++
 rtl/jtframe_cen_ratio_meter.sv | 148 ++++++++++++++
 tb/tb_jtframe_cen_ratio_meter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_cen_ratio_meter_pkg.sv
// rtl/jtframe_cen_ratio_meter_pkg.sv - shared constants and helpers for the cen ratio meter
package jtframe_cen_meter_pkg;

  // FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // Largest gap_max - gap_min spread that still counts as clean
  localparam int JIT_TOL = 1;

  // Increment v and hold at the all-ones value of a w-bit field (w <= 32)
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] ones;
    ones    = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    sat_inc = (v >= ones) ? ones : v + 32'd1;
  endfunction

endpackage

// File: rtl/jtframe_cen_ratio_meter_gap_tracker.sv
// rtl/jtframe_cen_ratio_meter_gap_tracker.sv - min/max pulse spacing tracker for the cen ratio meter
module jtframe_cen_gap_tracker
  import jtframe_cen_meter_pkg::*;
#(
  parameter int WC = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          cen_q,
  input  logic          en,
  // Outputs already include this cycle's pulse so the caller can capture
  // the final window cycle on the same edge as its own counters.
  output logic [WC-1:0] gap_min,
  output logic [WC-1:0] gap_max,
  output logic          two_seen
);

  logic          seen_q, seen_d;
  logic          two_q,  two_d;
  logic [WC-1:0] gap_q,  gap_d;
  logic [WC-1:0] min_q,  min_d;
  logic [WC-1:0] max_q,  max_d;

  // Gap counter starts at the first pulse; later pulses fold it into min/max
  always_comb begin
    seen_d = seen_q;
    two_d  = two_q;
    gap_d  = gap_q;
    min_d  = min_q;
    max_d  = max_q;
    if (clear) begin
      seen_d = 1'b0;
      two_d  = 1'b0;
      gap_d  = '0;
      min_d  = '0;
      max_d  = '0;
    end else if (en) begin
      if (cen_q) begin
        if (seen_q) begin
          min_d = (!two_q || gap_q < min_q) ? gap_q : min_q;
          max_d = (!two_q || gap_q > max_q) ? gap_q : max_q;
          two_d = 1'b1;
        end
        seen_d = 1'b1;
        gap_d  = WC'(1);
      end else if (seen_q) begin
        gap_d = WC'(sat_inc(32'(gap_q), WC));
      end
    end
  end

  // Tracker state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= 1'b0;
      two_q  <= 1'b0;
      gap_q  <= '0;
      min_q  <= '0;
      max_q  <= '0;
    end else begin
      seen_q <= seen_d;
      two_q  <= two_d;
      gap_q  <= gap_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  assign gap_min  = min_d;
  assign gap_max  = max_d;
  assign two_seen = two_d;

endmodule

// File: rtl/jtframe_cen_ratio_meter.sv
// rtl/jtframe_cen_ratio_meter.sv - counts cen pulses per m-cycle window; gap tracking under JTFRAME_CEN_METER_GAP_EN
module jtframe_cen_ratio_meter
  import jtframe_cen_meter_pkg::*;
#(
  parameter int WC = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [WC-1:0] m,
  input  logic          start,
  input  logic          cont,
  output logic          busy,
  output logic          valid,
  output logic [WC-1:0] n_meas,
  output logic [WC-1:0] gap_min,
  output logic [WC-1:0] gap_max,
  output logic          jitter_err
);

  logic [1:0]    state_q,  state_d;
  logic [WC-1:0] m_q,      m_d;
  logic [WC-1:0] win_q,    win_d;
  logic [WC-1:0] cnt_q,    cnt_d;
  logic          busy_q,   busy_d;
  logic          valid_q,  valid_d;
  logic [WC-1:0] n_meas_q, n_meas_d;
  logic [WC-1:0] win_nxt;
  logic          last_win;

  // Window counter runs 1..m; the m-th MEASURE cycle is the last one
  assign win_nxt  = win_q + WC'(1);
  assign last_win = (state_q == ST_MEASURE) && (win_nxt == m_q);

  // FSM, window and pulse counting, result capture on the last window cycle
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    n_meas_d = n_meas_q;
    case (state_q)
      ST_IDLE: begin
        if (start && m != '0) begin
          m_d     = m;
          win_d   = '0;
          cnt_d   = '0;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        win_d = win_nxt;
        cnt_d = cnt_q + WC'(cen);
        if (last_win) begin
          n_meas_d = cnt_d;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        win_d   = '0;
        cnt_d   = '0;
        state_d = cont ? ST_MEASURE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Main state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      m_q      <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      n_meas_q <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      n_meas_q <= n_meas_d;
    end
  end

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign n_meas = n_meas_q;

`ifdef JTFRAME_CEN_METER_GAP_EN
  logic [WC-1:0] trk_min, trk_max;
  logic          trk_two;
  logic [WC-1:0] gmin_q, gmin_d;
  logic [WC-1:0] gmax_q, gmax_d;
  logic          jit_q,  jit_d;

  jtframe_cen_gap_tracker #(.WC(WC)) u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_q != ST_MEASURE),
    .cen_q    (cen),
    .en       (state_q == ST_MEASURE),
    .gap_min  (trk_min),
    .gap_max  (trk_max),
    .two_seen (trk_two)
  );

  // Gap results follow n_meas; fewer than two pulses reports zeros
  always_comb begin
    gmin_d = gmin_q;
    gmax_d = gmax_q;
    jit_d  = jit_q;
    if (last_win) begin
      gmin_d = trk_two ? trk_min : '0;
      gmax_d = trk_two ? trk_max : '0;
      jit_d  = trk_two && ((trk_max - trk_min) > WC'(JIT_TOL));
    end
  end

  // Gap result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gmin_q <= '0;
      gmax_q <= '0;
      jit_q  <= 1'b0;
    end else begin
      gmin_q <= gmin_d;
      gmax_q <= gmax_d;
      jit_q  <= jit_d;
    end
  end

  assign gap_min    = gmin_q;
  assign gap_max    = gmax_q;
  assign jitter_err = jit_q;
`else
  assign gap_min    = '0;
  assign gap_max    = '0;
  assign jitter_err = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_cen_ratio_meter.sv
// tb/tb_jtframe_cen_ratio_meter.sv - directed self-checking bench for jtframe_cen_ratio_meter
module tb_jtframe_cen_ratio_meter;

  localparam int WC = 10;
`ifdef JTFRAME_CEN_METER_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          cen;
  logic [WC-1:0] m_in;
  logic          start;
  logic          cont;
  logic          busy;
  logic          valid;
  logic [WC-1:0] n_meas;
  logic [WC-1:0] gap_min;
  logic [WC-1:0] gap_max;
  logic          jitter_err;

  int errors = 0;
  int checks = 0;
  int acc    = 0;

  jtframe_cen_ratio_meter #(.WC(WC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .m          (m_in),
    .start      (start),
    .cont       (cont),
    .busy       (busy),
    .valid      (valid),
    .n_meas     (n_meas),
    .gap_min    (gap_min),
    .gap_max    (gap_max),
    .jitter_err (jitter_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int gexp(input int v);
    return GAP_EN ? v : 0;
  endfunction

  // 0: n=3/m=8 fractional generator, 1: always high, 2: always low, 3: pulses at 2,3,7
  function automatic logic pattern(input int mode, input int i);
    case (mode)
      0: begin
        acc += 3;
        if (acc >= 8) begin
          acc -= 8;
          return 1'b1;
        end
        return 1'b0;
      end
      1: return 1'b1;
      2: return 1'b0;
      default: return (i == 2 || i == 3 || i == 7);
    endcase
  endfunction

  task automatic run_window(input string tag, input int mlen, input int mode, input int exp_n,
                            input int exp_min, input int exp_max, input int exp_jit);
    int early_valid;
    int busy_low;
    early_valid = 0;
    busy_low    = 0;
    m_in  = WC'(mlen);
    start = 1'b1;
    cen   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= mlen; i++) begin
      cen = pattern(mode, i);
      if (valid) early_valid++;
      if (!busy) busy_low++;
      step();
    end
    cen = 1'b1;
    check({tag, "_valid_at_m+1"}, 32'(valid), 1);
    check({tag, "_early_valid"}, early_valid, 0);
    check({tag, "_busy_gaps"}, busy_low, 0);
    check({tag, "_n_meas"}, 32'(n_meas), exp_n);
    check({tag, "_gap_min"}, 32'(gap_min), gexp(exp_min));
    check({tag, "_gap_max"}, 32'(gap_max), gexp(exp_max));
    check({tag, "_jitter"}, 32'(jitter_err), gexp(exp_jit));
    step();
    cen = 1'b0;
    check({tag, "_valid_drop"}, 32'(valid), 0);
    check({tag, "_busy_drop"}, 32'(busy), 0);
    check({tag, "_n_hold"}, 32'(n_meas), exp_n);
  endtask

  initial begin
    int nvalid;
    int badpos;
    int badn;
    int vb;
    int vv;

    rst_n = 1'b0;
    cen   = 1'b0;
    m_in  = '0;
    start = 1'b0;
    cont  = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_n_meas", 32'(n_meas), 0);
    check("rst_gap_min", 32'(gap_min), 0);
    check("rst_gap_max", 32'(gap_max), 0);
    check("rst_jitter", 32'(jitter_err), 0);
    rst_n = 1'b1;
    step();

    acc = 0;
    run_window("frac", 800, 0, 300, 2, 3, 0);
    run_window("ones", 16, 1, 16, 1, 1, 0);
    run_window("zeros", 16, 2, 0, 0, 0, 0);
    run_window("pulses", 10, 3, 3, 1, 4, 1);

    // Continuous mode, m=5, cen always high; a stray start while busy
    cont  = 1'b1;
    cen   = 1'b1;
    m_in  = WC'(5);
    start = 1'b1;
    step();
    start = 1'b0;
    nvalid = 0;
    badpos = 0;
    badn   = 0;
    for (int k = 1; k <= 18; k++) begin
      if (k == 8) begin
        start = 1'b1;
        m_in  = WC'(3);
      end
      if (k == 10) start = 1'b0;
      if (k == 14) cont = 1'b0;
      if (valid) begin
        nvalid++;
        if (k % 6 != 0) badpos++;
        if (n_meas !== WC'(5)) badn++;
      end
      step();
    end
    check("cont_valid_count", nvalid, 3);
    check("cont_valid_period", badpos, 0);
    check("cont_n_meas", badn, 0);
    check("cont_stop_busy", 32'(busy), 0);
    check("cont_gap_min", 32'(gap_min), gexp(1));

    // Asynchronous reset in mid-window
    m_in  = WC'(20);
    start = 1'b1;
    cen   = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_n_meas", 32'(n_meas), 0);
    check("mid_rst_gap_min", 32'(gap_min), 0);
    check("mid_rst_gap_max", 32'(gap_max), 0);
    check("mid_rst_jitter", 32'(jitter_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    check("post_rst_idle_busy", 32'(busy), 0);
    check("post_rst_idle_valid", 32'(valid), 0);
    run_window("fresh", 4, 1, 4, 1, 1, 0);

    // start with m=0 must be refused
    m_in  = '0;
    start = 1'b1;
    cen   = 1'b1;
    vb = 0;
    vv = 0;
    repeat (4) begin
      step();
      if (busy) vb++;
      if (valid) vv++;
    end
    start = 1'b0;
    check("m0_busy", vb, 0);
    check("m0_valid", vv, 0);
    check("m0_n_hold", 32'(n_meas), 4);

    // Repeat of the fractional measurement
    acc = 0;
    run_window("frac2", 800, 0, 300, 2, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
